// File: rtl/lcd_bus_arbiter.sv
// HD44780 LCD port arbiter: per-string locking among NREQ writers plus LCD write timing.
// Round-robin by default; define LCD_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module lcd_bus_arbiter #(
    parameter int NREQ    = 2,
    parameter int T_SETUP = 2,
    parameter int T_EPW   = 12,
    parameter int T_HOLD  = 2,
    parameter int T_EXEC  = 1000,
    parameter int T_CLEAR = 41000
) (
    input  logic              clk2,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_rs,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   ack,
    output logic [NREQ-1:0]   grant,
    output logic              busy,
    output logic [7:0]        lcd_db,
    output logic              lcd_rs,
    output logic              lcd_rw,
    output logic              lcd_e
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {IDLE, SETUP, EPULSE, HOLD, WAIT} state_t;

    state_t          state_q;
    logic [15:0]     cnt_q;
    logic [NREQ-1:0] ack_q;
    logic [NREQ-1:0] grant_q;
    logic [7:0]      db_q;
    logic            rs_q;
    logic            e_q;
    logic            last_q;
`ifndef LCD_ARB_FIXED_PRIO_EN
    logic [IW-1:0]   rr_ptr_q;
    logic [IW-1:0]   rr_ptr_d;
    logic [IW-1:0]   scan_idx;
`endif

    logic [NREQ-1:0] cand;
    logic [NREQ-1:0] win_oh;
    logic [IW-1:0]   win_idx;
    logic            win_vld;
    logic            is_clear;

    // NOTE: every signal of this block gets a default first so no latch is inferred.
    always_comb begin
        // A locked owner that still requests is the only candidate; otherwise the lock lapses.
        cand    = ((req & grant_q) != '0) ? (req & grant_q) : req;
        win_vld = 1'b0;
        win_idx = '0;
`ifdef LCD_ARB_FIXED_PRIO_EN
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (cand[k]) begin
                win_vld = 1'b1;
                win_idx = IW'(k);
            end
        end
`else
        scan_idx = '0;
        // Walk downward so the candidate nearest rr_ptr_q is assigned last and wins.
        for (int k = NREQ - 1; k >= 0; k--) begin
            scan_idx = IW'((int'(rr_ptr_q) + k) % NREQ);
            if (cand[scan_idx]) begin
                win_vld = 1'b1;
                win_idx = scan_idx;
            end
        end
        rr_ptr_d = (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
`endif
        win_oh   = NREQ'(1) << win_idx;
        is_clear = !rs_q && (db_q == 8'h01 || db_q == 8'h02 || db_q == 8'h03);
    end

    // NOTE: all state and registered outputs update with non-blocking assignments only.
    always_ff @(posedge clk2) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ack_q    <= '0;
            grant_q  <= '0;
            db_q     <= '0;
            rs_q     <= 1'b0;
            e_q      <= 1'b0;
            last_q   <= 1'b0;
`ifndef LCD_ARB_FIXED_PRIO_EN
            rr_ptr_q <= '0;
`endif
        end else begin
            ack_q <= '0;
            if (state_q != IDLE) cnt_q <= cnt_q - 16'd1;
            case (state_q)
                IDLE: begin
                    if (win_vld) begin
                        ack_q    <= win_oh;
                        grant_q  <= win_oh;
                        db_q     <= req_data[{win_idx, 3'b000} +: 8];
                        rs_q     <= req_rs[win_idx];
                        last_q   <= req_last[win_idx];
                        cnt_q    <= 16'(T_SETUP);
                        state_q  <= SETUP;
`ifndef LCD_ARB_FIXED_PRIO_EN
                        rr_ptr_q <= rr_ptr_d;
`endif
                    end else begin
                        grant_q <= '0;
                    end
                end
                SETUP: if (cnt_q == 16'd1) begin
                    state_q <= EPULSE;
                    cnt_q   <= 16'(T_EPW);
                    e_q     <= 1'b1;
                end
                EPULSE: if (cnt_q == 16'd1) begin
                    state_q <= HOLD;
                    cnt_q   <= 16'(T_HOLD);
                    e_q     <= 1'b0;
                end
                HOLD: if (cnt_q == 16'd1) begin
                    state_q <= WAIT;
                    cnt_q   <= is_clear ? 16'(T_CLEAR) : 16'(T_EXEC);
                end
                WAIT: if (cnt_q == 16'd1) begin
                    state_q <= IDLE;
                    if (last_q) grant_q <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ack    = ack_q;
    assign grant  = grant_q;
    assign busy   = (state_q != IDLE);
    assign lcd_db = db_q;
    assign lcd_rs = rs_q;
    assign lcd_rw = 1'b0;
    assign lcd_e  = e_q;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Self-checking bench for lcd_bus_arbiter: a beat-timeline model checked every cycle,
// plus directed scenarios with hand-computed timing and ordering expectations.
module tb_lcd_bus_arbiter;
    localparam int NREQ    = 2;
    localparam int T_SETUP = 2;
    localparam int T_EPW   = 12;
    localparam int T_HOLD  = 2;
    localparam int T_EXEC  = 1000;
    localparam int T_CLEAR = 41000;

    logic              clk2 = 1'b0;
    logic              rst  = 1'b1;
    logic [NREQ-1:0]   req      = '0;
    logic [8*NREQ-1:0] req_data = '0;
    logic [NREQ-1:0]   req_rs   = '0;
    logic [NREQ-1:0]   req_last = '0;
    logic [NREQ-1:0]   ack;
    logic [NREQ-1:0]   grant;
    logic              busy;
    logic [7:0]        lcd_db;
    logic              lcd_rs;
    logic              lcd_rw;
    logic              lcd_e;

    always #5 clk2 = ~clk2;

    lcd_bus_arbiter #(
        .NREQ(NREQ), .T_SETUP(T_SETUP), .T_EPW(T_EPW), .T_HOLD(T_HOLD),
        .T_EXEC(T_EXEC), .T_CLEAR(T_CLEAR)
    ) dut (
        .clk2(clk2), .rst(rst), .req(req), .req_data(req_data), .req_rs(req_rs),
        .req_last(req_last), .ack(ack), .grant(grant), .busy(busy),
        .lcd_db(lcd_db), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       rs;
        logic       last;
    } beat_t;

    beat_t txq [NREQ][$];
    int    tests  = 0;
    int    fails  = 0;
    int    cyc    = 0;
    bit    chk_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Requesters: hold the head beat of each queue until it is acknowledged.
    always @(negedge clk2) begin
        for (int i = 0; i < NREQ; i++) begin
            if (ack[i] && txq[i].size() > 0) void'(txq[i].pop_front());
            if (txq[i].size() > 0) begin
                req[i]           = 1'b1;
                req_data[8*i+:8] = txq[i][0].data;
                req_rs[i]        = txq[i][0].rs;
                req_last[i]      = txq[i][0].last;
            end else begin
                req[i] = 1'b0;
            end
        end
    end

    // Model: a beat is a window of offsets after its ack; only the window length depends on the byte.
    int         m_off   = -1;
    int         m_len   = 0;
    int         m_owner = -1;
    int         m_rr    = 0;
    int         m_w     = -1;
    logic [7:0] m_db    = '0;
    logic       m_rs    = 1'b0;
    logic       m_last  = 1'b0;

    always @(posedge clk2) begin
        cyc++;
        if (rst) begin
            m_off = -1; m_owner = -1; m_rr = 0; m_db = '0; m_rs = 1'b0; m_last = 1'b0;
        end else if (m_off >= 0) begin
            m_off++;
            if (m_off == m_len) begin
                m_off = -1;
                if (m_last) m_owner = -1;
            end
        end else begin
            m_w = -1;
            if (m_owner >= 0 && !req[m_owner]) m_owner = -1;
            if (m_owner >= 0) m_w = m_owner;
            else begin
`ifdef LCD_ARB_FIXED_PRIO_EN
                for (int k = 0; k < NREQ; k++) if (m_w < 0 && req[k]) m_w = k;
`else
                for (int k = 0; k < NREQ; k++) if (m_w < 0 && req[(m_rr + k) % NREQ]) m_w = (m_rr + k) % NREQ;
`endif
            end
            if (m_w >= 0) begin
                m_owner = m_w;
                m_db    = req_data[8*m_w+:8];
                m_rs    = req_rs[m_w];
                m_last  = req_last[m_w];
                m_len   = T_SETUP + T_EPW + T_HOLD +
                          ((!m_rs && (m_db == 8'h01 || m_db == 8'h02 || m_db == 8'h03)) ? T_CLEAR : T_EXEC);
                m_rr    = (m_w + 1) % NREQ;
                m_off   = 0;
            end
        end
    end

    function automatic logic [NREQ-1:0] oh(input int i);
        oh = (i < 0) ? '0 : (NREQ'(1) << i);
    endfunction

    logic [NREQ-1:0] x_ack, x_grant;
    logic            x_busy, x_e;

    always @(negedge clk2) begin
        if (chk_en) begin
            x_ack   = (m_off == 0) ? oh(m_owner) : '0;
            x_grant = oh(m_owner);
            x_busy  = (m_off >= 0);
            x_e     = (m_off >= T_SETUP) && (m_off < T_SETUP + T_EPW);
            tests++;
            if ({ack, grant, busy, lcd_e, lcd_db, lcd_rs, lcd_rw} !==
                {x_ack, x_grant, x_busy, x_e, m_db, m_rs, 1'b0}) begin
                fails++;
                $display("FAIL cycle %0d outputs: ack=%b grant=%b busy=%b e=%b db=%h rs=%b rw=%b, expected ack=%b grant=%b busy=%b e=%b db=%h rs=%b rw=0",
                         cyc, ack, grant, busy, lcd_e, lcd_db, lcd_rs, lcd_rw,
                         x_ack, x_grant, x_busy, x_e, m_db, m_rs);
            end
        end
    end

    // Event log for the directed scenarios.
    int         ack_cyc[$];
    int         ack_who[$];
    logic [7:0] e_db[$];
    logic       e_rs[$];
    int         e_cnt    = 0;
    int         busy_cnt = 0;
    logic       e_prev   = 1'b0;

    always @(negedge clk2) begin
        for (int i = 0; i < NREQ; i++) begin
            if (ack[i]) begin
                ack_cyc.push_back(cyc);
                ack_who.push_back(i);
            end
        end
        if (lcd_e && !e_prev) begin
            e_db.push_back(lcd_db);
            e_rs.push_back(lcd_rs);
        end
        e_prev = lcd_e;
        if (lcd_e) e_cnt++;
        if (busy) busy_cnt++;
    end

    task automatic clear_logs();
        ack_cyc.delete(); ack_who.delete(); e_db.delete(); e_rs.delete();
        e_cnt = 0; busy_cnt = 0;
    endtask

    task automatic push(input int i, input logic [7:0] d, input logic rs, input logic last);
        beat_t b;
        b.data = d; b.rs = rs; b.last = last;
        txq[i].push_back(b);
    endtask

    function automatic bit all_done();
        all_done = !busy;
        for (int i = 0; i < NREQ; i++) if (txq[i].size() != 0) all_done = 1'b0;
    endfunction

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        do begin
            @(posedge clk2); #1;
            n++;
        end while (!all_done() && n < budget);
        check({name, "_timeout"}, int'(n >= budget), 0);
    endtask

    localparam int BEAT = 1 + T_SETUP + T_EPW + T_HOLD + T_EXEC;

    int t0;
    int n;
    int order_exp[4];

    initial begin
        repeat (2) @(posedge clk2);
        #1;
        chk_en = 1'b1;
        check("rst_ack", int'(ack), 0);
        check("rst_grant", int'(grant), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_db", int'(lcd_db), 0);
        check("rst_rs", int'(lcd_rs), 0);
        check("rst_rw", int'(lcd_rw), 0);
        check("rst_e", int'(lcd_e), 0);
        rst = 1'b0;
        @(posedge clk2); #1;

        // Single 'C' character.
        clear_logs();
        t0 = cyc;
        push(0, 8'h43, 1'b1, 1'b1);
        wait_done("single", 2000);
        check("single_ack_count", ack_cyc.size(), 1);
        check("single_ack_latency", ack_cyc[0] - t0, 1);
        check("single_e_width", e_cnt, 12);
        check("single_busy_cycles", busy_cnt, 1016);
        check("single_busy_fall", cyc - t0, 1017);
        check("single_db", int'(e_db[0]), 8'h43);
        check("single_rs", int'(e_rs[0]), 1);
        check("single_grant_after", int'(grant), 0);

        // Clear instruction followed by 'A': the clear's wait spans 41000 cycles.
        clear_logs();
        push(0, 8'h01, 1'b0, 1'b1);
        push(0, 8'h41, 1'b1, 1'b1);
        wait_done("clear", 45000);
        check("clear_ack_count", ack_cyc.size(), 2);
        check("clear_ack_gap", ack_cyc[1] - ack_cyc[0], 41017);
        check("clear_db", int'(e_db[0]), 8'h01);
        check("clear_rs", int'(e_rs[0]), 0);
        check("clear_next_db", int'(e_db[1]), 8'h41);

        // Locked string "Sal" from req0 while req1 waits with 'X'.
        clear_logs();
        push(0, 8'h53, 1'b1, 1'b0);
        push(0, 8'h61, 1'b1, 1'b0);
        push(0, 8'h6c, 1'b1, 1'b1);
        repeat (3) @(posedge clk2);
        #1;
        push(1, 8'h58, 1'b1, 1'b1);
        wait_done("lock", 6000);
        check("lock_ack_count", ack_cyc.size(), 4);
        check("lock_seq0", int'(e_db[0]), 8'h53);
        check("lock_seq1", int'(e_db[1]), 8'h61);
        check("lock_seq2", int'(e_db[2]), 8'h6c);
        check("lock_seq3", int'(e_db[3]), 8'h58);
        check("lock_req1_last", ack_who[3], 1);
        check("lock_req1_gap", ack_cyc[3] - ack_cyc[2], BEAT);

        // Two single-beat strings from each requester, all pending together.
        clear_logs();
`ifdef LCD_ARB_FIXED_PRIO_EN
        order_exp = '{0, 0, 1, 1};
`else
        order_exp = '{0, 1, 0, 1};
`endif
        push(0, 8'h30, 1'b1, 1'b1);
        push(0, 8'h31, 1'b1, 1'b1);
        push(1, 8'h32, 1'b1, 1'b1);
        push(1, 8'h33, 1'b1, 1'b1);
        wait_done("rr", 6000);
        check("rr_ack_count", ack_cyc.size(), 4);
        for (int k = 0; k < 4; k++) check($sformatf("rr_order%0d", k), ack_who[k], order_exp[k]);

        // req0 leaves its string open and withdraws; req1 gets the first IDLE slot.
        clear_logs();
        push(0, 8'h70, 1'b1, 1'b0);
        repeat (3) @(posedge clk2);
        #1;
        push(1, 8'h71, 1'b1, 1'b1);
        wait_done("drop", 4000);
        check("drop_ack_count", ack_cyc.size(), 2);
        check("drop_second_is_req1", ack_who[1], 1);
        check("drop_gap", ack_cyc[1] - ack_cyc[0], BEAT);
        check("drop_grant_after", int'(grant), 0);

        // Reset while E is high, then a fresh beat.
        clear_logs();
        push(0, 8'h5a, 1'b1, 1'b1);
        n = 0;
        do begin
            @(posedge clk2); #1;
            n++;
        end while (!lcd_e && n < 50);
        check("rst_mid_reach_e", int'(lcd_e), 1);
        repeat (3) @(posedge clk2);
        #1;
        rst = 1'b1;
        for (int i = 0; i < NREQ; i++) txq[i].delete();
        @(posedge clk2); #1;
        check("rst_mid_e", int'(lcd_e), 0);
        check("rst_mid_grant", int'(grant), 0);
        check("rst_mid_busy", int'(busy), 0);
        rst = 1'b0;
        @(posedge clk2); #1;
        clear_logs();
        t0 = cyc;
        push(0, 8'h46, 1'b1, 1'b1);
        wait_done("fresh", 2000);
        check("fresh_ack_count", ack_cyc.size(), 1);
        check("fresh_ack_latency", ack_cyc[0] - t0, 1);
        check("fresh_db", int'(e_db[0]), 8'h46);
        check("fresh_e_width", e_cnt, 12);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
